// File: rtl/sync_fifo_pf.sv
// Single-clock FIFO with exact occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_pf #(
  parameter int DATA_WD   = 8,
  parameter int ADDR_WD   = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               winc,
  input  logic [DATA_WD-1:0] wdata,
  output logic               wfull,
  output logic               afull,
  input  logic               rinc,
  output logic [DATA_WD-1:0] rdata,
  output logic               rempty,
  output logic               aempty,
  output logic [ADDR_WD:0]   count,
  input  logic               err_clr,
  output logic               overflow,
  output logic               underflow
);

  localparam int CW    = ADDR_WD + 1;
  localparam int DEPTH = 1 << ADDR_WD;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [DATA_WD-1:0] mem [DEPTH];
  logic [CW-1:0]      wptr;
  logic [CW-1:0]      rptr;
  logic [CW-1:0]      count_next;
  logic               wa;
  logic               ra;
  logic               mem_rd;

  // Accepts are qualified by the registered flags, so a rejected request never moves a pointer.
  assign wa         = winc & ~wfull;
  assign ra         = rinc & ~rempty;
  assign count_next = count + CW'(wa) - CW'(ra);

`ifdef SYNC_FIFO_FWFT_EN
  // Output register holds the head word; refill it whenever it is empty or being popped.
  logic out_valid;
  logic out_valid_next;

  assign mem_rd         = (wptr != rptr) && (!out_valid || ra);
  assign out_valid_next = mem_rd | (out_valid & ~ra);
`else
  assign mem_rd = ra;
`endif

  // NOTE: the storage array has no reset; only pointers and flags define validity,
  // which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wa) mem[wptr[ADDR_WD-1:0]] <= wdata;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      rdata     <= '0;
      wfull     <= 1'b0;
      rempty    <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
      out_valid <= 1'b0;
`endif
    end else begin
      if (wa) wptr <= wptr + CW'(1);
      if (mem_rd) begin
        rptr  <= rptr + CW'(1);
        rdata <= mem[rptr[ADDR_WD-1:0]];
      end

      count  <= count_next;
      wfull  <= (count_next == DEPTH_C);
      afull  <= (count_next >= AFULL_C);
      aempty <= (count_next <= AEMPTY_C);
`ifdef SYNC_FIFO_FWFT_EN
      out_valid <= out_valid_next;
      rempty    <= ~out_valid_next;
`else
      rempty <= (count_next == '0);
`endif

      // A set condition on the same edge as err_clr keeps the flag high.
      if (winc && wfull)  overflow  <= 1'b1;
      else if (err_clr)   overflow  <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

endmodule
